// File: rtl/pal_cfg_pkg.sv
// pal_cfg_pkg
//   Shared definitions for the PAL serial configuration streamer.
//   - state_t      : streamer FSM states
//   - pal_cfg_bits : configuration image length for an N-input, M-output,
//                    P-product-term PAL fabric (2*N*P + P*M); also used by
//                    PAL models that consume the stream
package pal_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    APPLY
  } state_t;

  // Each product term sees the true and complement of every input (2*N*P)
  // and each output selects from every product term (P*M).
  function automatic int pal_cfg_bits(input int n, input int m, input int p);
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_halfper.sv
// pal_cfg_halfper
//   Half-period timer for the serial configuration clock. Counts CLK_DIV
//   system clocks and pulses o_tick on the last one, then starts over.
// Ports
//   i_clk     : system clock
//   i_res     : asynchronous reset, active-high
//   i_restart : hold the count at zero (used while not shifting)
//   o_tick    : high on the final clock of each CLK_DIV-cycle half-period
module pal_cfg_halfper #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_res,
  input  logic i_restart,
  output logic o_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_cnt;

  // Tick is suppressed during restart so the first half-period after a
  // restart is always a full CLK_DIV cycles long.
  assign o_tick = !i_restart && (r_cnt == LAST);

  // The counter wraps on each tick so back-to-back half-periods need no
  // explicit restart from the FSM.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/pal_cfg_streamer.sv
// pal_cfg_streamer
//   Transmit side of the PAL serial configuration interface. Accepts
//   configuration words over a valid/ready port and shifts them out LSB-first
//   as cfg_clk/cfg_bit, then raises cfg_en once the whole image is loaded.
// Ports
//   i_clk        : system clock, rising edge
//   i_res        : asynchronous reset, active-high
//   i_start      : pulse, begin a new configuration load (ignored while busy)
//   i_wr_data    : configuration word, bit 0 sent first
//   i_wr_valid   : i_wr_data valid
//   o_wr_ready   : word accepted this cycle when valid is also high
//   o_cfg_clk    : serial config clock, idle low
//   o_cfg_bit    : serial config data, sampled by the PAL on cfg_clk rise
//   o_cfg_en     : image loaded and active
//   o_busy       : load in progress
//   o_done       : one-cycle pulse after the final bit has been shifted
module pal_cfg_streamer
  import pal_cfg_pkg::*;
#(
  parameter int N       = 8,
  parameter int M       = 6,
  parameter int P       = 18,
  parameter int W       = 8,
  parameter int CLK_DIV = 2
) (
  input  logic         i_clk,
  input  logic         i_res,
  input  logic         i_start,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_wr_valid,
  output logic         o_wr_ready,
  output logic         o_cfg_clk,
  output logic         o_cfg_bit,
  output logic         o_cfg_en,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CFG_BITS = pal_cfg_bits(N, M, P);
  localparam int BW       = $clog2(CFG_BITS + 1);
  localparam int IW       = (W > 1) ? $clog2(W) : 1;

  state_t          r_state;
  logic [BW-1:0]   r_bit_cnt;
  logic [IW-1:0]   r_bit_idx;
  logic [W-1:0]    r_shift;
  logic            r_wr_ready;
  logic            r_cfg_clk;
  logic            r_cfg_bit;
  logic            r_cfg_en;
  logic            r_busy;
  logic            r_done;

  logic            w_restart;
  logic            w_tick;
  logic [BW-1:0]   w_bit_cnt_nxt;
  logic [W-1:0]    w_shift_nxt;

  // The half-period timer only runs while shifting, so every SHIFT_LO that
  // follows a word handshake starts from a fresh count.
  assign w_restart     = !((r_state == SHIFT_LO) || (r_state == SHIFT_HI));
  assign w_bit_cnt_nxt = r_bit_cnt + BW'(1);
  assign w_shift_nxt   = r_shift >> 1;

  pal_cfg_halfper #(
    .CLK_DIV (CLK_DIV)
  ) u_halfper (
    .i_clk     (i_clk),
    .i_res     (i_res),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Load FSM. cfg_bit is updated only on the cycle cfg_clk falls (or on the
  // word capture), so it is stable across every high phase. The image ends on
  // the bit count rather than the word boundary, which drops the unused upper
  // bits of a partial final word without requesting another word.
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_wr_ready <= 1'b0;
      r_cfg_clk  <= 1'b0;
      r_cfg_bit  <= 1'b0;
      r_cfg_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, APPLY: begin
          if (i_start) begin
            r_state    <= LOAD;
            r_cfg_en   <= 1'b0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (i_wr_valid && r_wr_ready) begin
            r_shift    <= i_wr_data;
            r_cfg_bit  <= i_wr_data[0];
            r_bit_idx  <= '0;
            r_wr_ready <= 1'b0;
            r_state    <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (w_tick) begin
            r_cfg_clk <= 1'b1;
            r_state   <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (w_tick) begin
            r_cfg_clk <= 1'b0;
            r_bit_cnt <= w_bit_cnt_nxt;
            if (w_bit_cnt_nxt == BW'(CFG_BITS)) begin
              r_state  <= APPLY;
              r_done   <= 1'b1;
              r_cfg_en <= 1'b1;
              r_busy   <= 1'b0;
            end else if (r_bit_idx == IW'(W - 1)) begin
              r_state    <= LOAD;
              r_wr_ready <= 1'b1;
            end else begin
              r_state   <= SHIFT_LO;
              r_shift   <= w_shift_nxt;
              r_cfg_bit <= w_shift_nxt[0];
              r_bit_idx <= r_bit_idx + IW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_wr_ready = r_wr_ready;
  assign o_cfg_clk  = r_cfg_clk;
  assign o_cfg_bit  = r_cfg_bit;
  assign o_cfg_en   = r_cfg_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_pal_cfg_streamer.sv
// tb_pal_cfg_streamer
//   Bench for pal_cfg_streamer. Three instances run side by side:
//     dut0 : defaults (396 bits, 50 words, CLK_DIV=2)
//     dut1 : N=2 M=1 P=2 (10 bits, 2 words), CLK_DIV=1
//     dut2 : N=2 M=2 P=3 (18 bits, 3 words), CLK_DIV=3
//   A timeline model predicts every output on every cycle from the words the
//   bench handed over; a PAL model captures cfg_bit on each cfg_clk rise.
module tb_pal_cfg_streamer;

  localparam int NB  [3] = '{396, 10, 18};
  localparam int NW  [3] = '{50, 2, 3};
  localparam int DIV [3] = '{2, 1, 3};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] startIn;
  logic [2:0] wrValid;
  logic [7:0] wrData [3];
  logic [2:0] wrReady;
  logic [2:0] cfgClk;
  logic [2:0] cfgBit;
  logic [2:0] cfgEn;
  logic [2:0] busyOut;
  logic [2:0] doneOut;

  int nCompared   = 0;
  int nMismatched = 0;
  int cycle       = 0;

  // model state
  bit         mBusy [3];
  bit         mWait [3];
  bit         mEn   [3];
  bit         eBit  [3];
  int         mBits [3];
  int         mTaken[3];
  int         lowStart[3];
  logic [7:0] words [3][64];
  bit         pStart[3];
  bit         pHs   [3];
  logic [7:0] pData [3];

  // PAL model and observed counts
  bit         palImg [3][400];
  bit         prevClk[3];
  int         actRises[3];
  int         actHs  [3];
  int         doneCnt[3];

  // stimulus control
  bit         startReq [3];
  int         validPct [3];
  bit         gapArm   [3];
  int         gapLeft  [3];
  bit         fixedMode[3];
  bit         busyStartEn = 1'b0;
  logic [7:0] fixedWords [2] = '{8'hA5, 8'hFF};

  always #5 clock = ~clock;

  pal_cfg_streamer #(.N(8), .M(6), .P(18), .W(8), .CLK_DIV(2)) dut0 (
    .i_clk(clock), .i_res(reset), .i_start(startIn[0]), .i_wr_data(wrData[0]),
    .i_wr_valid(wrValid[0]), .o_wr_ready(wrReady[0]), .o_cfg_clk(cfgClk[0]),
    .o_cfg_bit(cfgBit[0]), .o_cfg_en(cfgEn[0]), .o_busy(busyOut[0]), .o_done(doneOut[0]));

  pal_cfg_streamer #(.N(2), .M(1), .P(2), .W(8), .CLK_DIV(1)) dut1 (
    .i_clk(clock), .i_res(reset), .i_start(startIn[1]), .i_wr_data(wrData[1]),
    .i_wr_valid(wrValid[1]), .o_wr_ready(wrReady[1]), .o_cfg_clk(cfgClk[1]),
    .o_cfg_bit(cfgBit[1]), .o_cfg_en(cfgEn[1]), .o_busy(busyOut[1]), .o_done(doneOut[1]));

  pal_cfg_streamer #(.N(2), .M(2), .P(3), .W(8), .CLK_DIV(3)) dut2 (
    .i_clk(clock), .i_res(reset), .i_start(startIn[2]), .i_wr_data(wrData[2]),
    .i_wr_valid(wrValid[2]), .o_wr_ready(wrReady[2]), .o_cfg_clk(cfgClk[2]),
    .o_cfg_bit(cfgBit[2]), .o_cfg_en(cfgEn[2]), .o_busy(busyOut[2]), .o_done(doneOut[2]));

   // Single comparison point: every check funnels through here so the
   // summary counts are exactly the ones stepped by the comparisons.
   task automatic compare(input string name, input int idx,
                          input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s (dut%0d, cycle %0d): actual %0h, required %0h",
                  name, idx, cycle, act, exp);
      end
   endtask

   // Reset clears the model to the all-zero idle picture.
   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         mBusy[i] = 0; mWait[i] = 0; mEn[i] = 0; eBit[i] = 0;
         mBits[i] = 0; mTaken[i] = 0; lowStart[i] = 0;
         pStart[i] = 0; pHs[i] = 0; prevClk[i] = 0;
      end
   endtask

   // Advance the timeline model by one cycle and compare all outputs. A bit
   // occupies 2*CLK_DIV cycles starting at lowStart: low for the first
   // CLK_DIV, high for the next CLK_DIV; its end is the next bit's start.
   task automatic checkOutput();
      bit eDone;
      bit eClk;
      int s;
      cycle++;
      for (int i = 0; i < 3; i++) begin
         eDone = 0;
         if (pStart[i]) begin
            pStart[i] = 0;
            if (!mBusy[i]) begin
               mBusy[i] = 1; mWait[i] = 1; mBits[i] = 0; mTaken[i] = 0; mEn[i] = 0;
            end
         end
         if (pHs[i]) begin
            pHs[i] = 0;
            words[i][mTaken[i]] = pData[i];
            mTaken[i]++;
            mWait[i] = 0;
            lowStart[i] = cycle;
            eBit[i] = pData[i][0];
         end
         if (mBusy[i] && !mWait[i] && (cycle - lowStart[i] == 2 * DIV[i])) begin
            mBits[i]++;
            if (mBits[i] == NB[i]) begin
               mBusy[i] = 0; mEn[i] = 1; eDone = 1;
            end else if (mBits[i] % 8 == 0) begin
               mWait[i] = 1;
            end else begin
               lowStart[i] = cycle;
               eBit[i] = words[i][mBits[i] / 8][mBits[i] % 8];
            end
         end
         s = cycle - lowStart[i];
         eClk = mBusy[i] && !mWait[i] && (s >= DIV[i]);

         compare("cfg_clk",  i, 32'(cfgClk[i]),  32'(eClk));
         compare("cfg_bit",  i, 32'(cfgBit[i]),  32'(eBit[i]));
         compare("wr_ready", i, 32'(wrReady[i]), 32'(mBusy[i] && mWait[i]));
         compare("busy",     i, 32'(busyOut[i]), 32'(mBusy[i]));
         compare("done",     i, 32'(doneOut[i]), 32'(eDone));
         compare("cfg_en",   i, 32'(cfgEn[i]),   32'(mEn[i]));

         if (cfgClk[i] === 1'b1 && !prevClk[i]) begin
            if (actRises[i] < 400) palImg[i][actRises[i]] = cfgBit[i];
            actRises[i]++;
         end
         if (doneOut[i] === 1'b1) doneCnt[i]++;
         prevClk[i] = (cfgClk[i] === 1'b1);
      end
   endtask

   // Drive inputs for the coming rising edge and note which events the model
   // must apply at the next sample.
   task automatic applyStimulus();
      for (int i = 0; i < 3; i++) begin
         startIn[i] = startReq[i] ||
                      (busyStartEn && mBusy[i] && ($urandom_range(0, 49) == 0));
         startReq[i] = 0;
         if (gapArm[i] && mBusy[i] && mWait[i] && mTaken[i] == 1 && gapLeft[i] == 0) begin
            gapLeft[i] = 20;
            gapArm[i] = 0;
         end
         if (gapLeft[i] > 0) begin
            wrValid[i] = 1'b0;
            gapLeft[i]--;
         end else begin
            wrValid[i] = ($urandom_range(0, 99) < validPct[i]);
         end
         if (fixedMode[i] && mTaken[i] < 2) wrData[i] = fixedWords[mTaken[i]];
         else wrData[i] = 8'($urandom);
         if (reset) begin
            pStart[i] = 0;
            pHs[i] = 0;
         end else begin
            pStart[i] = startIn[i];
            pHs[i] = wrValid[i] && mBusy[i] && mWait[i];
            pData[i] = wrData[i];
            if (wrValid[i] && wrReady[i] === 1'b1) actHs[i]++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clock);
      if (reset) modelReset();
      checkOutput();
      applyStimulus();
   endtask

   task automatic beginRound();
      for (int i = 0; i < 3; i++) begin
         actHs[i] = 0; actRises[i] = 0; doneCnt[i] = 0; startReq[i] = 1;
      end
   endtask

   // Run until every instance has pulsed done, then a few more cycles so a
   // second done pulse or a dropped cfg_en would still be seen.
   task automatic runUntilDone(input int maxCycles);
      int n = 0;
      bit fin = 0;
      while (!fin && n < maxCycles) begin
         tick();
         n++;
         fin = (doneCnt[0] > 0) && (doneCnt[1] > 0) && (doneCnt[2] > 0);
      end
      compare("load_finished", 9, 32'(fin), 32'd1);
      busyStartEn = 0;
      repeat (8) tick();
   endtask

   // Whole-load checks against hand-computed image sizes and the words sent.
   task automatic finalChecks();
      int bad;
      for (int i = 0; i < 3; i++) begin
         compare("handshakes", i, 32'(actHs[i]), 32'(NW[i]));
         compare("rises",      i, 32'(actRises[i]), 32'(NB[i]));
         compare("done_count", i, 32'(doneCnt[i]), 32'd1);
         compare("final_en",   i, 32'(cfgEn[i]), 32'd1);
         bad = 0;
         for (int r = 0; r < NB[i]; r++) begin
            if (palImg[i][r] != words[i][r / 8][r % 8]) bad++;
         end
         compare("image", i, 32'(bad), 32'd0);
      end
   endtask

   initial begin
      logic [9:0] lit;
      logic [9:0] got;
      int n;
      startIn = '0;
      wrValid = '0;
      for (int i = 0; i < 3; i++) begin
         wrData[i] = '0; validPct[i] = 100; gapArm[i] = 0; gapLeft[i] = 0;
         fixedMode[i] = 0; startReq[i] = 0; actRises[i] = 0; actHs[i] = 0;
         doneCnt[i] = 0;
      end
      modelReset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         compare("reset_clk",  i, 32'(cfgClk[i]),  32'd0);
         compare("reset_en",   i, 32'(cfgEn[i]),   32'd0);
         compare("reset_busy", i, 32'(busyOut[i]), 32'd0);
      end

      $display("[TB] reset in the middle of a high phase");
      startReq[0] = 1;
      n = 0;
      while (!(mBits[0] >= 3 && cfgClk[0] === 1'b1) && n < 300) begin
         tick();
         n++;
      end
      compare("reached_shift_hi", 0, 32'(cfgClk[0]), 32'd1);
      reset = 1'b1;
      tick();
      compare("rst_mid_clk",   0, 32'(cfgClk[0]),  32'd0);
      compare("rst_mid_busy",  0, 32'(busyOut[0]), 32'd0);
      compare("rst_mid_ready", 0, 32'(wrReady[0]), 32'd0);
      compare("rst_mid_bit",   0, 32'(cfgBit[0]),  32'd0);
      reset = 1'b0;
      repeat (10) tick();

      $display("[TB] round 1: full loads, fixed words on dut1, gap on dut2");
      validPct[0] = 100; validPct[1] = 100; validPct[2] = 70;
      fixedMode[1] = 1;
      gapArm[2] = 1;
      beginRound();
      runUntilDone(4000);
      finalChecks();
      lit = 10'h3A5;
      got = '0;
      for (int r = 0; r < 10; r++) got[r] = palImg[1][r];
      compare("dut1_bits", 1, 32'(got), 32'(lit));
      compare("dut1_word2", 1, 32'(words[1][1]), 32'h0FF);

      $display("[TB] round 2: restart from APPLY, random gaps, starts while busy");
      fixedMode[1] = 0;
      validPct[0] = 80; validPct[1] = 60; validPct[2] = 90;
      gapArm[0] = 1;
      busyStartEn = 1;
      beginRound();
      runUntilDone(6000);
      finalChecks();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
